// File: rtl/alu.sv
// Registered 32-bit integer ALU: combines a zero-extended 8-bit operand with a
// 32-bit operand under a 3-bit opcode and presents the result one clock later.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  num1,
    input  logic [31:0] num2,
    input  logic [2:0]  op,
    output logic [31:0] ans
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOT  = 3'b100,
        OP_SLT  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    logic [31:0] a32;
    logic [31:0] ans_d;
    logic [31:0] ans_q;
    logic        slt_bit;
    op_e         op_sel;

    assign a32    = {24'b0, num1};
    assign op_sel = op_e'(op);

    // a32 is never negative, so the signed compare only matters for negative num2
    assign slt_bit = $signed(a32) < $signed(num2);

    always_comb begin
        ans_d = 32'h0;
        case (op_sel)
            OP_ADD:  ans_d = a32 + num2;
            OP_SUB:  ans_d = a32 - num2;
            OP_AND:  ans_d = a32 & num2;
            OP_OR:   ans_d = a32 | num2;
            OP_NOT:  ans_d = ~a32;
            OP_SLT:  ans_d = {31'b0, slt_bit};
            OP_RSV6: ans_d = 32'h0;
            OP_RSV7: ans_d = 32'h0;
            default: ans_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ans_q <= 32'h0;
        end else begin
            ans_q <= ans_d;
        end
    end

    assign ans = ans_q;

endmodule

// File: tb/tb_alu.sv
// Directed, self-checking bench for the registered ALU; each scenario task
// drives its own vectors and compares ans against hand-computed values.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [7:0]  num1;
    logic [31:0] num2;
    logic [2:0]  op;
    logic [31:0] ans;

    int checks;
    int failures;

    alu dut (
        .clk  (clk),
        .rst  (rst),
        .num1 (num1),
        .num2 (num2),
        .op   (op),
        .ans  (ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector, take one rising edge, and settle 1ns past it.
    task automatic step(input logic [7:0] n1, input logic [31:0] n2, input logic [2:0] o);
        num1 = n1;
        num2 = n2;
        op   = o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(8'hFF, 32'hFFFF_FFFF, 3'b000);
        checks++;
        if (ans !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL reset: got %h expected %h", ans, 32'h0000_0000);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_ops();
        logic [7:0]  n1_tab  [6] = '{8'h02, 8'hFF, 8'hFE, 8'hAA, 8'hF0, 8'h81};
        logic [2:0]  op_tab  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        logic [31:0] exp_tab [6] = '{32'h0000_0003, 32'h0000_00FE, 32'h0000_0000,
                                     32'h0000_00AB, 32'hFFFF_FF0F, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            step(n1_tab[i], 32'h0000_0001, op_tab[i]);
            checks++;
            if (ans !== exp_tab[i]) begin
                failures++;
                $display("[TB] FAIL basic_op%0d: got %h expected %h", op_tab[i], ans, exp_tab[i]);
            end
        end
    endtask

    task automatic test_slt();
        logic [7:0]  n1_tab  [4] = '{8'h00, 8'h00, 8'h05, 8'h05};
        logic [31:0] n2_tab  [4] = '{32'h1, 32'hFFFF_FFFF, 32'h5, 32'h6};
        logic [31:0] exp_tab [4] = '{32'h1, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 4; i++) begin
            step(n1_tab[i], n2_tab[i], 3'b101);
            checks++;
            if (ans !== exp_tab[i]) begin
                failures++;
                $display("[TB] FAIL slt_case%0d: got %h expected %h", i, ans, exp_tab[i]);
            end
        end
    endtask

    task automatic test_wraparound();
        step(8'hFF, 32'hFFFF_FF01, 3'b000);
        checks++;
        if (ans !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL add_wrap: got %h expected %h", ans, 32'h0000_0000);
        end
        step(8'h00, 32'h0000_0001, 3'b001);
        checks++;
        if (ans !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL sub_wrap: got %h expected %h", ans, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_reserved();
        // Preload a non-zero result so a reserved op must actively clear it.
        step(8'h10, 32'h0000_0020, 3'b000);
        checks++;
        if (ans !== 32'h0000_0030) begin
            failures++;
            $display("[TB] FAIL reserved_preload: got %h expected %h", ans, 32'h0000_0030);
        end
        step(8'hFF, 32'hFFFF_FFFF, 3'b110);
        checks++;
        if (ans !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reserved_110: got %h expected %h", ans, 32'h0);
        end
        step(8'h12, 32'h0000_0003, 3'b011);
        step(8'h5A, 32'hDEAD_BEEF, 3'b111);
        checks++;
        if (ans !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reserved_111: got %h expected %h", ans, 32'h0);
        end
    endtask

    task automatic test_latency();
        step(8'h03, 32'h0000_0004, 3'b000);
        // New inputs must not reach ans until the following rising edge.
        num1 = 8'h01;
        num2 = 32'h0000_0100;
        op   = 3'b011;
        #2;
        checks++;
        if (ans !== 32'h0000_0007) begin
            failures++;
            $display("[TB] FAIL latency_hold: got %h expected %h", ans, 32'h0000_0007);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ans !== 32'h0000_0101) begin
            failures++;
            $display("[TB] FAIL latency_update: got %h expected %h", ans, 32'h0000_0101);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  n1_tab  [4] = '{8'h0F, 8'h0F, 8'hC3, 8'h00};
        logic [31:0] n2_tab  [4] = '{32'h0000_00F0, 32'h1234_5678, 32'h0000_00FF, 32'h8000_0000};
        logic [2:0]  op_tab  [4] = '{3'b011, 3'b010, 3'b001, 3'b101};
        logic [31:0] exp_tab [4] = '{32'h0000_00FF, 32'h0000_0008, 32'hFFFF_FFC4, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            step(n1_tab[i], n2_tab[i], op_tab[i]);
            checks++;
            if (ans !== exp_tab[i]) begin
                failures++;
                $display("[TB] FAIL back_to_back%0d: got %h expected %h", i, ans, exp_tab[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        step(8'h40, 32'h0000_0002, 3'b000);
        checks++;
        if (ans !== 32'h0000_0042) begin
            failures++;
            $display("[TB] FAIL midreset_before: got %h expected %h", ans, 32'h0000_0042);
        end
        rst = 1'b1;
        step(8'h40, 32'h0000_0002, 3'b000);
        checks++;
        if (ans !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: got %h expected %h", ans, 32'h0);
        end
        rst = 1'b0;
        step(8'h40, 32'h0000_0002, 3'b000);
        checks++;
        if (ans !== 32'h0000_0042) begin
            failures++;
            $display("[TB] FAIL midreset_resume: got %h expected %h", ans, 32'h0000_0042);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        num1     = 8'h00;
        num2     = 32'h0;
        op       = 3'b000;
        @(negedge clk);
        test_reset();
        test_basic_ops();
        test_slt();
        test_wraparound();
        test_reserved();
        test_latency();
        test_back_to_back();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
